// File: rtl/decoder_pkg.sv
// Load/store size codes shared between the instruction decoder and the LSU.
package decoder_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

endpackage

// File: rtl/lsu_pkg.sv
// LSU state encoding, byte-enable bases and request-shaping helpers.
package lsu_pkg;

  import decoder_pkg::*;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  function automatic logic is_byte(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] size);
    return (size == LDST_H) || (size == LDST_HU);
  endfunction

  // Every size that is neither byte nor half is treated as a word access.
  function automatic logic [3:0] be_calc(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = BE_W;
    if (is_byte(size))      be = BE_B << addr_lo;
    else if (is_half(size)) be = BE_H << {addr_lo[1], 1'b0};
    return be;
  endfunction

  function automatic logic [31:0] wd_calc(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] rep;
    rep = wd;
    if (is_byte(size))      rep = {4{wd[7:0]}};
    else if (is_half(size)) rep = {2{wd[15:0]}};
    return rep;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (is_half(size))       mis = addr_lo[0];
    else if (!is_byte(size)) mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_rd_extend.sv
// Selects and sign/zero-extends load data; outputs zero while en_i is low.
module lsu_rd_extend
  import decoder_pkg::*;
(
  input  logic [31:0] rd_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        en_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_i[7:0];
    case (addr_lo_i)
      2'b01:   byte_sel = rd_i[15:8];
      2'b10:   byte_sel = rd_i[23:16];
      2'b11:   byte_sel = rd_i[31:24];
      default: byte_sel = rd_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rd_i[31:16] : rd_i[15:0];

    data_o = '0;
    if (en_i) begin
      case (size_i)
        LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
        LDST_BU: data_o = {24'h0, byte_sel};
        LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
        LDST_HU: data_o = {16'h0, half_sel};
        default: data_o = rd_i;
      endcase
    end
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: core request -> byte-enabled memory transaction, stalls until done.
// Optional LSU_MISALIGN_EXC_EN adds lsu_misalign_o and rejects misaligned H/W accesses.
module riscv_lsu
  import decoder_pkg::*;
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
`ifdef LSU_MISALIGN_EXC_EN
  output logic        lsu_misalign_o,
`endif
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state_q, state_d;
  logic [2:0]  size_q;
  logic [31:0] cnt_q;
  logic [31:0] rd_ext;
  logic        ext_en;
  logic        timeout;
  logic        misalign;

`ifdef LSU_MISALIGN_EXC_EN
  assign misalign = is_misaligned(core_size_i, core_addr_i[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign timeout      = (TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_CYC - 1);
  assign core_stall_o = core_req_i && (state_q != DONE);
  assign ext_en       = (state_q == BUSY) && mem_ready_i;

  // Extender doubles as the zero source for timeout and misalign completions.
  lsu_rd_extend u_rd_extend (
    .rd_i      (mem_rd_i),
    .size_i    (size_q),
    .addr_lo_i (mem_addr_o[1:0]),
    .en_i      (ext_en),
    .data_o    (rd_ext)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (core_req_i) state_d = misalign ? DONE : BUSY;
      BUSY:    if (mem_ready_i || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_rd_o      <= '0;
      bus_err_o      <= 1'b0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_be_o       <= '0;
      mem_addr_o     <= '0;
      mem_wd_o       <= '0;
      size_q         <= '0;
      cnt_q          <= '0;
`ifdef LSU_MISALIGN_EXC_EN
      lsu_misalign_o <= 1'b0;
`endif
    end else begin
      bus_err_o      <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
      lsu_misalign_o <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (core_req_i) begin
            if (misalign) begin
              core_rd_o      <= rd_ext;
`ifdef LSU_MISALIGN_EXC_EN
              lsu_misalign_o <= 1'b1;
`endif
            end else begin
              mem_req_o  <= 1'b1;
              mem_we_o   <= core_we_i;
              mem_addr_o <= core_addr_i;
              mem_be_o   <= be_calc(core_size_i, core_addr_i[1:0]);
              mem_wd_o   <= wd_calc(core_size_i, core_wd_i);
              size_q     <= core_size_i;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 32'd1;
          // A ready in the timeout cycle still completes normally.
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            cnt_q     <= '0;
            if (!mem_we_o) core_rd_o <= rd_ext;
          end else if (timeout) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            cnt_q     <= '0;
            core_rd_o <= rd_ext;
            bus_err_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu (default and TIMEOUT_CYC=3 instances).
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, mem_ready;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd, mem_rd;

  logic [31:0] rd, maddr, mwd;
  logic        stall, berr, mreq, mwe;
  logic [3:0]  mbe;

  logic [31:0] t_rd, t_maddr, t_mwd;
  logic        t_stall, t_berr, t_mreq, t_mwe;
  logic [3:0]  t_mbe;

`ifdef LSU_MISALIGN_EXC_EN
  logic mis, t_mis;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(rd), .core_stall_o(stall), .bus_err_o(berr),
    .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe),
    .mem_addr_o(maddr), .mem_wd_o(mwd),
`ifdef LSU_MISALIGN_EXC_EN
    .lsu_misalign_o(mis),
`endif
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  riscv_lsu #(.TIMEOUT_CYC(3)) dut_to (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(t_rd), .core_stall_o(t_stall), .bus_err_o(t_berr),
    .mem_req_o(t_mreq), .mem_we_o(t_mwe), .mem_be_o(t_mbe),
    .mem_addr_o(t_maddr), .mem_wd_o(t_mwd),
`ifdef LSU_MISALIGN_EXC_EN
    .lsu_misalign_o(t_mis),
`endif
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_size = 3'b000;
    core_addr = '0; core_wd = '0; mem_rd = '0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_req",  {31'b0, mreq}, 32'd0);
    chk("rst_we",   {31'b0, mwe},  32'd0);
    chk("rst_rd",   rd,            32'd0);
    chk("rst_be",   {28'b0, mbe},  32'd0);
    chk("rst_addr", maddr,         32'd0);
    chk("rst_wd",   mwd,           32'd0);
    chk("rst_berr", {31'b0, berr}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Load word, ready in the first BUSY cycle
    core_req = 1'b1; core_we = 1'b0; core_size = 3'b010; core_addr = 32'h100;
    #1 chk("w_stall0", {31'b0, stall}, 32'd1);
    tick();
    chk("w_req",    {31'b0, mreq},  32'd1);
    chk("w_be",     {28'b0, mbe},   32'hF);
    chk("w_we",     {31'b0, mwe},   32'd0);
    chk("w_addr",   maddr,          32'h100);
    chk("w_stall1", {31'b0, stall}, 32'd1);
    mem_rd = 32'hDEADBEEF; mem_ready = 1'b1;
    tick();
    chk("w_stall2", {31'b0, stall}, 32'd0);
    chk("w_rd",     rd,             32'hDEADBEEF);
    chk("w_req_dn", {31'b0, mreq},  32'd0);
    mem_ready = 1'b0;
    tick();
    chk("w_noreacc", {31'b0, mreq},  32'd0);
    chk("w_idle_st", {31'b0, stall}, 32'd1);
    core_req = 1'b0;
    tick();

    // Signed byte load from the top byte lane
    core_req = 1'b1; core_size = 3'b000; core_addr = 32'h103;
    tick();
    chk("b_be", {28'b0, mbe}, 32'h8);
    mem_rd = 32'h80FF0000; mem_ready = 1'b1;
    tick();
    chk("b_rd", rd, 32'hFFFFFF80);
    mem_ready = 1'b0; core_req = 1'b0;
    tick();

    // Same access unsigned
    core_req = 1'b1; core_size = 3'b100; core_addr = 32'h103;
    tick();
    chk("bu_be", {28'b0, mbe}, 32'h8);
    mem_ready = 1'b1;
    tick();
    chk("bu_rd", rd, 32'h00000080);
    mem_ready = 1'b0; core_req = 1'b0;
    tick();

    // Halfword store: replicated data, load result untouched
    core_req = 1'b1; core_we = 1'b1; core_size = 3'b001; core_addr = 32'h202; core_wd = 32'h1234ABCD;
    tick();
    chk("s_we", {31'b0, mwe}, 32'd1);
    chk("s_be", {28'b0, mbe}, 32'hC);
    chk("s_wd", mwd,          32'hABCDABCD);
    mem_rd = 32'h55555555; mem_ready = 1'b1;
    tick();
    chk("s_rd",    rd,             32'h00000080);
    chk("s_stall", {31'b0, stall}, 32'd0);
    mem_ready = 1'b0; core_req = 1'b0; core_we = 1'b0;
    tick();

    // Timeout on dut_to; default dut stays BUSY
    core_req = 1'b1; core_size = 3'b010; core_addr = 32'h500;
    tick();
    core_req = 1'b0;
    chk("to_berr_c1", {31'b0, t_berr}, 32'd0);
    tick();
    chk("to_berr_c2", {31'b0, t_berr}, 32'd0);
    tick();
    chk("to_berr_c3", {31'b0, t_berr}, 32'd0);
    tick();
    chk("to_berr_c4", {31'b0, t_berr}, 32'd1);
    chk("to_rd",      t_rd,            32'd0);
    chk("to_req",     {31'b0, t_mreq}, 32'd0);
    chk("nto_busy",   {31'b0, mreq},   32'd1);
    tick();
    chk("to_berr_c5", {31'b0, t_berr}, 32'd0);

    // Asynchronous reset while BUSY, then a late ready
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_req", {31'b0, mreq}, 32'd0);
    tick();
    rst_n = 1'b1; mem_rd = 32'hFFFFFFFF; mem_ready = 1'b1;
    tick();
    chk("late_rdy_req", {31'b0, mreq}, 32'd0);
    chk("late_rdy_rd",  rd,            32'd0);
    mem_ready = 1'b0;
    tick();

    // Ready in the same cycle the timeout would fire
    core_req = 1'b1; core_size = 3'b010; core_addr = 32'h600;
    tick();
    core_req = 1'b0;
    tick(); tick();
    mem_rd = 32'h13579BDF; mem_ready = 1'b1;
    tick();
    chk("co_berr", {31'b0, t_berr}, 32'd0);
    chk("co_rd",   t_rd,            32'h13579BDF);
    mem_ready = 1'b0;
    tick();

    // Ready delayed five BUSY cycles, request dropped meanwhile
    core_req = 1'b1; core_size = 3'b001; core_addr = 32'h306;
    tick();
    core_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("dly_req", {31'b0, mreq}, 32'd1);
      if (i == 4) begin
        mem_rd = 32'h80017FFF; mem_ready = 1'b1;
      end
      tick();
    end
    chk("dly_rd",     rd,            32'hFFFF8001);
    chk("dly_req_dn", {31'b0, mreq}, 32'd0);
    chk("dly_berr",   {31'b0, berr}, 32'd0);
    mem_ready = 1'b0;
    tick();
    chk("dly_idle1", {31'b0, mreq}, 32'd0);
    tick();
    chk("dly_idle2", {31'b0, mreq}, 32'd0);

    // Ready while idle is ignored
    mem_rd = 32'h11111111; mem_ready = 1'b1;
    tick(); tick();
    chk("idle_rdy_rd",  rd,            32'hFFFF8001);
    chk("idle_rdy_req", {31'b0, mreq}, 32'd0);
    mem_ready = 1'b0;
    tick();

`ifdef LSU_MISALIGN_EXC_EN
    core_req = 1'b1; core_size = 3'b010; core_addr = 32'h101;
    #1 chk("ma_req0",   {31'b0, mreq},  32'd0);
    chk("ma_stall0",    {31'b0, stall}, 32'd1);
    tick();
    chk("ma_flag",      {31'b0, mis},   32'd1);
    chk("ma_req1",      {31'b0, mreq},  32'd0);
    chk("ma_stall1",    {31'b0, stall}, 32'd0);
    chk("ma_rd",        rd,             32'd0);
    core_req = 1'b0;
    tick();
    chk("ma_flag_clr",  {31'b0, mis},   32'd0);
    chk("ma_req2",      {31'b0, mreq},  32'd0);
`else
    // Misaligned HU: addr[0] ignored, lower half selected
    core_req = 1'b1; core_size = 3'b101; core_addr = 32'h301;
    tick();
    chk("hu_be", {28'b0, mbe}, 32'h3);
    mem_rd = 32'h12348765; mem_ready = 1'b1;
    tick();
    chk("hu_rd", rd, 32'h00008765);
    mem_ready = 1'b0; core_req = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit that executes the memory requests issued by the instruction decoder (mem_req/mem_we/mem_size) on behalf of the core.
- Turns a core-side request into a byte-enabled, word-oriented data-memory transaction with a ready handshake.
- Extends returned load data per size.
- Stalls the core until the access completes.
- Sits between the core datapath and the data memory.

Parameters:
TIMEOUT_CYC, 0, max cycles to wait for mem_ready_i in BUSY; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
core_req_i  in  1  core memory request (held for the whole instruction)
core_we_i  in  1  1 = store, 0 = load
core_size_i  in  3  LDST_B=000, LDST_H=001, LDST_W=010, LDST_BU=100, LDST_HU=101
core_addr_i  in  32  byte address (rs1+imm)
core_wd_i  in  32  store data (rs2)
core_rd_o  out  32  extended load data, valid while core_stall_o=0 in DONE
core_stall_o  out  1  stall request to core
bus_err_o  out  1  one-cycle pulse in DONE on timeout
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  32  byte address
mem_wd_o  out  32  replicated write data
mem_rd_i  in  32  memory read word
mem_ready_i  in  1  memory completes transaction this cycle

Behaviour:
- Reset: clock clk_i; reset is asynchronous, active-low (rst_ni). During reset: state=IDLE; core_rd_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0, bus_err_o=0, timeout counter=0.
- core_stall_o is combinational: core_req_i && state!=DONE.
- IDLE + core_req_i: latch we, size, addr, wd; go to BUSY.
- BUSY:
  - mem_req_o=1, driven from registers.
  - mem_we_o = latched we; mem_addr_o = latched addr.
- BUSY + mem_ready_i: capture extended mem_rd_i into core_rd_o (loads only; stores leave core_rd_o unchanged); go to DONE.
- DONE: lasts one cycle; mem_req_o=0, stall deasserted so the core retires the instruction; then IDLE. The still-high core_req_i is not re-accepted in DONE.
- Minimum latency: request in cycle 0, memory ready in cycle 1, retire in cycle 2 (2 stall cycles).
- Byte enables (from addr[1:0]):
  - B/BU: 0001<<addr[1:0].
  - H/HU: 0011<<{addr[1],0}.
  - W: 1111.
- Write data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Stores with BU/HU behave as B/H. Sizes 011/110/111 behave as W.
- Load extension:
  - B: sign-extend byte addr[1:0]. BU: zero-extend it.
  - H: sign-extend half addr[1]. HU: zero-extend it.
  - W: whole word.
- Misaligned H/W (base build): low address bits are ignored (H uses addr[1] only, W uses none).
- Timeout: TIMEOUT_CYC>0 and counter reaches TIMEOUT_CYC in BUSY → DONE with core_rd_o=0, bus_err_o=1 for that cycle. The counter clears on leaving BUSY.
- Boundary and corner cases:
  - mem_ready_i in IDLE or DONE is ignored.
  - core_req_i dropping in BUSY does not abort the access; the FSM still completes through DONE.
  - mem_ready_i and timeout in the same cycle: ready wins, no error.
  - Reset mid-BUSY drops mem_req_o immediately; a late mem_ready_i after reset is ignored.

Optional Feature:
Macro LSU_MISALIGN_EXC_EN.
- Defined:
  - Adds port lsu_misalign_o (out, 1).
  - A misaligned request (H/HU with addr[0]=1; W with addr[1:0]!=0) never asserts mem_req_o.
  - IDLE goes directly to DONE with lsu_misalign_o=1 for one cycle and core_rd_o=0. Latency is 1 stall cycle.
- Undefined: the port is absent; misaligned accesses use the base-build alignment rule above.

Decomposition:
- Package lsu_pkg:
  - lsu_state_t enum {IDLE, BUSY, DONE};
  - byte-enable base constants;
  - LDST_* size codes imported from decoder_pkg (not duplicated).
- One natural sub-module: lsu_rd_extend, combinational (mem_rd_i, size, addr[1:0]) → 32-bit extended data. It is reused by the timeout/misalign paths as a zero source.

Test Plan:
- Load W, addr 0x100, mem_rd_i=0xDEADBEEF, ready in 1st BUSY cycle → mem_be_o=1111, stall high 2 cycles, core_rd_o=0xDEADBEEF in DONE.
- Load B, addr 0x103, mem_rd_i=0x80FF_0000 → be=1000, core_rd_o=0xFFFFFF80. Repeat as BU → core_rd_o=0x00000080.
- Store H, addr 0x202, wd=0x1234ABCD → mem_we_o=1, be=1100, mem_wd_o=0xABCDABCD, core_rd_o unchanged.
- Ready delayed 5 cycles, core_req_i dropped in BUSY → mem_req_o held 5 cycles, DONE once, no re-accept.
- TIMEOUT_CYC=3, no ready → bus_err_o pulses in cycle 4 after accept, core_rd_o=0. Separately, reset asserted mid-BUSY → mem_req_o=0 asynchronously, later ready ignored.
- With LSU_MISALIGN_EXC_EN, load W at 0x101 → mem_req_o never 1, lsu_misalign_o=1 next cycle, stall 1 cycle.
